bios_loader: RTL and testbench
==============================

BIOS_LOADER -- requirements
Module: bios_loader

Interface
- REQ-001 Parameter DW, default 8: ROM/RAM data width in bits.
- REQ-002 Parameter AW, default 14: ROM address width; image length is 2**AW words.
- REQ-003 Parameter RAW, default 20: RAM address width.
- REQ-004 Parameter BASE, default 20'hFC000: RAM address of ROM word 0.
- REQ-005 clock  in  1  sole clock; one clock; all state on its rising edge.
- REQ-006 reset_n  in  1  asynchronous, active-low reset.
- REQ-007 start  in  1  copy request, level-sampled.
- REQ-008 rom_ce  out  1  read enable to the upstream ROM.
- REQ-009 rom_a  out  AW  ROM word address.
- REQ-010 rom_d  in  DW  ROM read data, valid the cycle after rom_ce.
- REQ-011 ram_req  out  1  write request to the RAM arbiter.
- REQ-012 ram_a  out  RAW  RAM write address.
- REQ-013 ram_d  out  DW  RAM write data.
- REQ-014 ram_ack  in  1  write accepted, single-cycle pulse.
- REQ-015 busy  out  1  copy in progress.
- REQ-016 done  out  1  image fully copied, sticky until reset.
- REQ-017 cpu_hold  out  1  keeps the CPU in reset until done.
- REQ-018 csum  out  DW  running modulo-2**DW sum of the copied words.

Function
- REQ-019 The FSM SHALL have states IDLE, FETCH, CAPTURE, WRITE, DONE.
- REQ-020 IDLE->FETCH when start=1; start SHALL be ignored in every other state.
- REQ-021 FETCH: rom_ce=1 and rom_a=counter for exactly one cycle, then ->CAPTURE.
- REQ-022 CAPTURE: register rom_d into ram_d, set ram_a=BASE+counter (truncated to RAW bits), assert ram_req, then ->WRITE.
- REQ-023 WRITE: hold ram_req, ram_a and ram_d stable until ram_ack=1 is sampled; ram_req SHALL be 0 on the cycle after the ack.
- REQ-024 On ack with counter=2**AW-1: ->DONE. Otherwise: counter+1, ->FETCH.
- REQ-025 The counter SHALL never wrap; no write SHALL occur beyond word 2**AW-1.
- REQ-026 ram_ack outside WRITE SHALL be ignored.
- REQ-027 busy=1 in FETCH, CAPTURE and WRITE; done=1 only in DONE; cpu_hold=~done.
- REQ-028 DONE SHALL be terminal; start SHALL have no effect there.
- REQ-029 rom_ce SHALL be 0 in every state except FETCH.
- REQ-030 Minimum cost per word: 3 cycles plus ack latency.

Reset
- REQ-031 reset_n=0 SHALL immediately force: state=IDLE, counter=0, rom_ce=0, rom_a=0, ram_req=0, ram_a=0, ram_d=0, busy=0, done=0, cpu_hold=1, csum=0.
- REQ-032 Reset during a copy SHALL drop ram_req without waiting for ram_ack; the next start SHALL restart the copy from word 0.

Configuration
- REQ-033 Macro BIOS_LOADER_CHECKSUM_EN, when defined: csum adds each word on its accepted ram_ack, modulo 2**DW.
- REQ-034 Without BIOS_LOADER_CHECKSUM_EN: csum SHALL be constant 0, the port SHALL remain present, and no adder SHALL be synthesized.

Structure
- REQ-035 Package next186_boot_pkg SHALL hold the FSM state enum and the default DW/AW/RAW/BASE constants.
- REQ-036 There SHALL be no sub-modules; the checksum accumulator is inline logic under the macro.

Verification (AW=4, BASE=20'hFC000, ROM model with 1-cycle latency, contents word i = 8'h10+i)
- REQ-037 Immediate ack: pulse start, ram_ack one cycle after each ram_req rises -> 16 writes of FC000..FC00F / 10..1F, 3 cycles per word, done=1, cpu_hold=0.
- REQ-038 Ack delayed 5 cycles on word 3 -> ram_req, ram_a=FC003 and ram_d=13 stay stable for 5 cycles, exactly one write.
- REQ-039 Reset asserted in WRITE of word 7 -> ram_req=0 immediately; a new start writes FC000 first; exactly 16 writes.
- REQ-040 start held high throughout, and asserted again after done -> no restart and no extra writes.
- REQ-041 BIOS_LOADER_CHECKSUM_EN defined -> csum=8'h78 at done; undefined -> csum=0 throughout.
- REQ-042 Spurious ram_ack in IDLE and FETCH -> counter unchanged, no skipped words.

Source files
------------

// File: rtl/next186_boot_pkg.sv
// Shared definitions for the BIOS loader: FSM state encoding and default
// geometry of the ROM image and the RAM it is copied into.
package next186_boot_pkg;

  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned AW_DEF   = 14;
  localparam int unsigned RAW_DEF  = 20;
  localparam logic [19:0] BASE_DEF = 20'hFC000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bios_loader_if.sv
// ROM read port and RAM write port of the BIOS loader, bundled together.
// The master modport is the loader side; the slave modport is the ROM/RAM side.
interface bios_loader_if
  import next186_boot_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned RAW = RAW_DEF
) ();

  logic           rom_ce;
  logic [AW-1:0]  rom_a;
  logic [DW-1:0]  rom_d;
  logic           ram_req;
  logic [RAW-1:0] ram_a;
  logic [DW-1:0]  ram_d;
  logic           ram_ack;

  modport master (
    output rom_ce, rom_a, ram_req, ram_a, ram_d,
    input  rom_d, ram_ack
  );

  modport slave (
    input  rom_ce, rom_a, ram_req, ram_a, ram_d,
    output rom_d, ram_ack
  );

endinterface

// File: rtl/bios_loader.sv
// BIOS loader: copies a 2**AW word ROM image into RAM starting at BASE,
// one word at a time (fetch, capture, write with ack handshake), then holds
// done high and releases the CPU.
// Optional feature macro: BIOS_LOADER_CHECKSUM_EN -- when defined, csum
// accumulates every accepted word modulo 2**DW; otherwise csum is tied to 0.
module bios_loader
  import next186_boot_pkg::*;
#(
  parameter int unsigned    DW   = DW_DEF,
  parameter int unsigned    AW   = AW_DEF,
  parameter int unsigned    RAW  = RAW_DEF,
  parameter logic [RAW-1:0] BASE = BASE_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  bios_loader_if.master        bus,
  output logic                 busy,
  output logic                 done,
  output logic                 cpu_hold,
  output logic [DW-1:0]        csum
);

  state_e         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           ram_req_q, ram_req_d;
  logic [RAW-1:0] ram_a_q, ram_a_d;
  logic [DW-1:0]  ram_d_q, ram_d_d;

  // State, word counter and RAM write port registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ram_req_q <= 1'b0;
      ram_a_q   <= '0;
      ram_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ram_req_q <= ram_req_d;
      ram_a_q   <= ram_a_d;
      ram_d_q   <= ram_d_d;
    end
  end

  // Next-state logic: one word per FETCH/CAPTURE/WRITE round; the last word
  // exits to DONE instead of advancing, so the counter never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_req_d = ram_req_q;
    ram_a_d   = ram_a_q;
    ram_d_d   = ram_d_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        ram_d_d   = bus.rom_d;
        ram_a_d   = BASE + RAW'(cnt_q);
        ram_req_d = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.ram_ack) begin
          ram_req_d = 1'b0;
          if (cnt_q == '1) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.rom_ce  = (state_q == ST_FETCH);
  assign bus.rom_a   = cnt_q;
  assign bus.ram_req = ram_req_q;
  assign bus.ram_a   = ram_a_q;
  assign bus.ram_d   = ram_d_q;

  assign busy     = (state_q == ST_FETCH) || (state_q == ST_CAPTURE) || (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign cpu_hold = ~done;

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q;

  // Running sum of every word the RAM accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if ((state_q == ST_WRITE) && bus.ram_ack) begin
      csum_q <= csum_q + ram_d_q;
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader with a 16-word image (AW=4).
// ROM word i holds 8'h10+i; the RAM side acks after a programmable delay.
module tb_bios_loader;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned RAW = 20;
  localparam logic [19:0] BASE = 20'hFC000;

`ifdef BIOS_LOADER_CHECKSUM_EN
  localparam logic [7:0] CSUM_EXP = 8'h78;
`else
  localparam logic [7:0] CSUM_EXP = 8'h00;
`endif

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          cpu_hold;
  logic [DW-1:0] csum;

  bios_loader_if #(.DW(DW), .AW(AW), .RAW(RAW)) bus ();

  bios_loader #(.DW(DW), .AW(AW), .RAW(RAW), .BASE(BASE)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .cpu_hold (cpu_hold),
    .csum     (csum)
  );

  int n_total = 0;
  int n_bad   = 0;

  int dly_word = 99;
  int dly      = 0;
  bit spur_en  = 1'b0;
  int wait_cnt = 0;

  logic [19:0] wr_a[$];
  logic [7:0]  wr_d[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM with one cycle of read latency.
  always @(posedge clock) begin
    if (bus.rom_ce) bus.rom_d <= 8'h10 + 8'(bus.rom_a);
  end

  // RAM responder: ack after the programmed delay, plus optional spurious acks.
  always @(negedge clock) begin
    if (bus.ram_req) wait_cnt = wait_cnt + 1;
    else             wait_cnt = 0;
    bus.ram_ack = (bus.ram_req &&
                   wait_cnt > ((32'(bus.ram_a[3:0]) == dly_word) ? dly : 0)) ||
                  (spur_en && reset_n && (bus.rom_ce || (!busy && !done)));
  end

  // Log every accepted write.
  always @(posedge clock) begin
    if (reset_n && bus.ram_req && bus.ram_ack) begin
      wr_a.push_back(bus.ram_a);
      wr_d.push_back(bus.ram_d);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_req(input logic [19:0] a);
    int c;
    c = 0;
    while (!(bus.ram_req && bus.ram_a == a) && c < 300) begin
      @(negedge clock);
      c++;
    end
    chk("req_reached", 32'(bus.ram_req && bus.ram_a == a), 32'd1);
  endtask

  task automatic check_image(input string tag);
    chk({tag, "_nwrites"}, 32'(wr_a.size()), 32'd16);
    for (int i = 0; i < 16 && i < wr_a.size(); i++) begin
      chk({tag, "_addr"}, 32'(wr_a[i]), 32'(BASE + 20'(i)));
      chk({tag, "_data"}, 32'(wr_d[i]), 32'(8'h10 + 8'(i)));
    end
  endtask

  task automatic apply_reset();
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    wr_a.delete();
    wr_d.delete();
  endtask

  initial begin
    int cyc;
    int n3;
    reset_n = 1'b0;
    start   = 1'b0;
    #12;
    chk("rst_rom_ce",   32'(bus.rom_ce),  32'd0);
    chk("rst_rom_a",    32'(bus.rom_a),   32'd0);
    chk("rst_ram_req",  32'(bus.ram_req), 32'd0);
    chk("rst_ram_a",    32'(bus.ram_a),   32'd0);
    chk("rst_ram_d",    32'(bus.ram_d),   32'd0);
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_done",     32'(done),        32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold),    32'd1);
    chk("rst_csum",     32'(csum),        32'd0);
    @(negedge clock); reset_n = 1'b1;

    // Immediate ack, single start pulse: 3 cycles per word.
    pulse_start();
    chk("a_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("a_cycles", 32'(cyc), 32'd48);
    check_image("a");
    chk("a_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("a_busy_end", 32'(busy),     32'd0);
    chk("a_csum",     32'(csum),     32'(CSUM_EXP));
    // start again after done: terminal state, nothing more written
    @(negedge clock); start = 1'b1;
    repeat (10) @(negedge clock);
    start = 1'b0;
    chk("a_no_restart", 32'(wr_a.size()), 32'd16);
    chk("a_done_held",  32'(done),        32'd1);

    // Word 3 acked late, start held high throughout.
    apply_reset();
    dly_word = 3;
    dly      = 5;
    @(negedge clock); start = 1'b1;
    wait_req(20'hFC003);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("b_hold_req", 32'(bus.ram_req), 32'd1);
      chk("b_hold_a",   32'(bus.ram_a),   32'hFC003);
      chk("b_hold_d",   32'(bus.ram_d),   32'h13);
    end
    wait_done(cyc);
    repeat (10) @(negedge clock);
    start = 1'b0;
    check_image("b");
    n3 = 0;
    foreach (wr_a[i]) if (wr_a[i] == 20'hFC003) n3++;
    chk("b_word3_once", 32'(n3), 32'd1);
    chk("b_csum", 32'(csum), 32'(CSUM_EXP));
    dly_word = 99;
    dly      = 0;

    // Spurious acks in IDLE and FETCH must not skip words.
    apply_reset();
    spur_en = 1'b1;
    repeat (3) @(negedge clock);
    chk("c_idle_ack_seen", 32'(bus.ram_ack), 32'd1);
    chk("c_idle_rom_a",    32'(bus.rom_a),   32'd0);
    pulse_start();
    wait_done(cyc);
    spur_en = 1'b0;
    check_image("c");

    // Reset in the WRITE of word 7, then restart from word 0.
    apply_reset();
    dly_word = 7;
    dly      = 1000;
    pulse_start();
    wait_req(20'hFC007);
    repeat (2) @(negedge clock);
    chk("d_pre_writes", 32'(wr_a.size()), 32'd7);
    reset_n = 1'b0;
    #1;
    chk("d_rst_req",  32'(bus.ram_req), 32'd0);
    chk("d_rst_busy", 32'(busy),        32'd0);
    chk("d_rst_hold", 32'(cpu_hold),    32'd1);
    chk("d_rst_a",    32'(bus.ram_a),   32'd0);
    chk("d_rst_csum", 32'(csum),        32'd0);
    dly_word = 99;
    dly      = 0;
    @(negedge clock); reset_n = 1'b1;
    wr_a.delete();
    wr_d.delete();
    pulse_start();
    wait_done(cyc);
    check_image("d");
    chk("d_csum", 32'(csum), 32'(CSUM_EXP));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
